// File: rtl/p6_pkg.sv
// rtl/p6_pkg.sv - P6 controller shared constants: states, opcodes, select codes (decode honours P6_BRANCH_LINK_EN)
package p6_pkg;

  // FSM state encodings
  localparam logic [4:0] S_RST      = 5'd0;
  localparam logic [4:0] S_IF1      = 5'd1;
  localparam logic [4:0] S_IF2      = 5'd2;
  localparam logic [4:0] S_UPD_PC   = 5'd3;
  localparam logic [4:0] S_DECODE   = 5'd4;
  localparam logic [4:0] S_WR_IMM   = 5'd5;
  localparam logic [4:0] S_GET_A    = 5'd6;
  localparam logic [4:0] S_GET_B    = 5'd7;
  localparam logic [4:0] S_EXEC     = 5'd8;
  localparam logic [4:0] S_EXEC_A0  = 5'd9;
  localparam logic [4:0] S_EXEC_CMP = 5'd10;
  localparam logic [4:0] S_WR_C     = 5'd11;
  localparam logic [4:0] S_ADDR     = 5'd12;
  localparam logic [4:0] S_LD_ADDR  = 5'd13;
  localparam logic [4:0] S_MEM_RD   = 5'd14;
  localparam logic [4:0] S_WR_MEM   = 5'd15;
  localparam logic [4:0] S_GET_D    = 5'd16;
  localparam logic [4:0] S_MEM_WR   = 5'd17;
  localparam logic [4:0] S_BRANCH   = 5'd18;
  localparam logic [4:0] S_HALT     = 5'd19;
  localparam logic [4:0] S_LINK     = 5'd20;
  localparam logic [4:0] S_JUMP     = 5'd21;

  // opcode field IR[15:13]
  localparam logic [2:0] OPC_BR   = 3'b001;
  localparam logic [2:0] OPC_LINK = 3'b010;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  // op field IR[12:11]
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_BX   = 2'b00;
  localparam logic [1:0] OP_BLX  = 2'b10;
  localparam logic [1:0] OP_BL   = 2'b11;

  // branch conditions IR[10:8]
  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_LE = 3'b100;

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;

  localparam logic [2:0] NSEL_RN = 3'b100;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b001;

  localparam logic [3:0] VSEL_MDATA  = 4'b1000;
  localparam logic [3:0] VSEL_SXIMM8 = 4'b0100;
  localparam logic [3:0] VSEL_PC1    = 4'b0010;
  localparam logic [3:0] VSEL_C      = 4'b0001;

  localparam logic [1:0] PCSEL_INC    = 2'd0;
  localparam logic [1:0] PCSEL_BRANCH = 2'd1;
  localparam logic [1:0] PCSEL_RD     = 2'd2;
  localparam logic [1:0] PCSEL_ZERO   = 2'd3;

  // First execute state for an instruction; anything unrecognised halts
  function automatic logic [4:0] decode_target(input logic [2:0] opcode, input logic [1:0] op);
    logic [4:0] t;
    case ({opcode, op})
      {OPC_MOV, OP_MOVI}: t = S_WR_IMM;
      {OPC_MOV, OP_MOVR}: t = S_GET_B;
      {OPC_ALU, OP_ADD},
      {OPC_ALU, OP_CMP},
      {OPC_ALU, OP_AND}:  t = S_GET_A;
      {OPC_ALU, OP_MVN}:  t = S_GET_B;
      {OPC_LDR, 2'b00},
      {OPC_STR, 2'b00}:   t = S_GET_A;
      {OPC_BR, 2'b00}:    t = S_BRANCH;
`ifdef P6_BRANCH_LINK_EN
      {OPC_LINK, OP_BL},
      {OPC_LINK, OP_BLX}: t = S_LINK;
      {OPC_LINK, OP_BX}:  t = S_GET_D;
`endif
      default:            t = S_HALT;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/p6_branch_cond.sv
// rtl/p6_branch_cond.sv - branch condition evaluator on status flags N/V/Z
module p6_branch_cond
  import p6_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       n,
  input  logic       v,
  input  logic       z,
  output logic       taken
);

  // Signed compare uses N xor V; codes above LE are reserved and never taken
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_LT: taken = n ^ v;
      COND_LE: taken = (n ^ v) | z;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/p6_controller.sv
// rtl/p6_controller.sv - P6 multi-cycle Moore control FSM; P6_BRANCH_LINK_EN adds BL/BX/BLX
module p6_controller
  import p6_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic [2:0] cond,
  input  logic       N,
  input  logic       V,
  input  logic       Z,
  output logic       load_ir,
  output logic       load_pc,
  output logic [1:0] pc_sel,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic [2:0] nsel,
  output logic [3:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       halted
);

  logic [4:0] state;
  logic [4:0] next_state;
  logic       cond_taken;
  logic       branch_taken;

  p6_branch_cond u_cond (
    .cond  (cond),
    .n     (N),
    .v     (V),
    .z     (Z),
    .taken (cond_taken)
  );

`ifdef P6_BRANCH_LINK_EN
  // BL reaches BRANCH through LINK and always jumps
  assign branch_taken = cond_taken | ((opcode == OPC_LINK) && (op == OP_BL));
`else
  assign branch_taken = cond_taken;
`endif

  // State register; reset pulls straight back to RST from any state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RST;
    else       state <= next_state;
  end

  // Next-state sequencing; the IR is stable for the whole instruction
  always_comb begin
    next_state = state;
    case (state)
      S_RST:      next_state = S_IF1;
      S_IF1:      next_state = S_IF2;
      S_IF2:      next_state = S_UPD_PC;
      S_UPD_PC:   next_state = S_DECODE;
      S_DECODE:   next_state = decode_target(opcode, op);
      S_WR_IMM:   next_state = S_IF1;
      S_GET_A:    next_state = (opcode == OPC_ALU) ? S_GET_B : S_ADDR;
      S_GET_B: begin
        if (opcode == OPC_MOV)  next_state = S_EXEC_A0;
        else if (op == OP_CMP)  next_state = S_EXEC_CMP;
        else                    next_state = S_EXEC;
      end
      S_EXEC:     next_state = S_WR_C;
      S_EXEC_A0:  next_state = (opcode == OPC_STR) ? S_MEM_WR : S_WR_C;
      S_EXEC_CMP: next_state = S_IF1;
      S_WR_C:     next_state = S_IF1;
      S_ADDR:     next_state = S_LD_ADDR;
      S_LD_ADDR:  next_state = (opcode == OPC_LDR) ? S_MEM_RD : S_GET_D;
      S_MEM_RD:   next_state = S_WR_MEM;
      S_WR_MEM:   next_state = S_IF1;
      S_MEM_WR:   next_state = S_IF1;
`ifdef P6_BRANCH_LINK_EN
      S_GET_D:    next_state = (opcode == OPC_STR) ? S_EXEC_A0 : S_JUMP;
      S_LINK:     next_state = (op == OP_BL) ? S_BRANCH : S_GET_D;
      S_JUMP:     next_state = S_IF1;
`else
      S_GET_D:    next_state = S_EXEC_A0;
`endif
      S_BRANCH:   next_state = S_IF1;
      S_HALT:     next_state = S_HALT;
      default:    next_state = S_HALT;
    endcase
  end

  // Output decode from state; only BRANCH also looks at the flags
  always_comb begin
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    pc_sel    = PCSEL_INC;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = MEM_NONE;
    nsel      = 3'b000;
    vsel      = 4'b0000;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    halted    = 1'b0;
    case (state)
      S_RST:      begin load_pc = 1'b1; pc_sel = PCSEL_ZERO; end
      S_IF1:      begin addr_sel = 1'b1; mem_cmd = MEM_READ; end
      S_IF2:      begin addr_sel = 1'b1; mem_cmd = MEM_READ; load_ir = 1'b1; end
      S_UPD_PC:   begin load_pc = 1'b1; pc_sel = PCSEL_INC; end
      S_WR_IMM:   begin nsel = NSEL_RN; vsel = VSEL_SXIMM8; write = 1'b1; end
      S_GET_A:    begin nsel = NSEL_RN; loada = 1'b1; end
      S_GET_B:    begin nsel = NSEL_RM; loadb = 1'b1; end
      S_EXEC:     loadc = 1'b1;
      S_EXEC_A0:  begin asel = 1'b1; loadc = 1'b1; end
      S_EXEC_CMP: loads = 1'b1;
      S_WR_C:     begin nsel = NSEL_RD; vsel = VSEL_C; write = 1'b1; end
      S_ADDR:     begin bsel = 1'b1; loadc = 1'b1; end
      S_LD_ADDR:  load_addr = 1'b1;
      S_MEM_RD:   mem_cmd = MEM_READ;
      S_WR_MEM:   begin nsel = NSEL_RD; vsel = VSEL_MDATA; write = 1'b1; mem_cmd = MEM_READ; end
      S_GET_D:    begin nsel = NSEL_RD; loadb = 1'b1; end
      S_MEM_WR:   mem_cmd = MEM_WRITE;
      S_BRANCH: begin
        if (branch_taken) begin
          load_pc = 1'b1;
          pc_sel  = PCSEL_BRANCH;
        end
      end
`ifdef P6_BRANCH_LINK_EN
      S_LINK:     begin nsel = NSEL_RN; vsel = VSEL_PC1; write = 1'b1; end
      S_JUMP:     begin load_pc = 1'b1; pc_sel = PCSEL_RD; end
`endif
      S_HALT:     halted = 1'b1;
      default:    ;
    endcase
  end

endmodule

// File: tb/tb_p6_controller.sv
// tb/tb_p6_controller.sv - self-checking bench for p6_controller (honours P6_BRANCH_LINK_EN)
module tb_p6_controller;

  logic       clk;
  logic       reset;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] cond;
  logic       N, V, Z;
  logic       load_ir, load_pc, addr_sel, load_addr, write;
  logic       loada, loadb, loadc, loads, asel, bsel, halted;
  logic [1:0] pc_sel, mem_cmd;
  logic [2:0] nsel;
  logic [3:0] vsel;

  int n_cmp = 0;
  int n_bad = 0;

  // expected control word per cycle, same bit order as obs()
  logic [22:0] exp_q[$];

  localparam logic [22:0] LIR = 23'd1 << 22;
  localparam logic [22:0] LPC = 23'd1 << 21;
  localparam logic [22:0] PC1 = 23'd1 << 19;
  localparam logic [22:0] PC2 = 23'd2 << 19;
  localparam logic [22:0] PC3 = 23'd3 << 19;
  localparam logic [22:0] ASE = 23'd1 << 18;
  localparam logic [22:0] LAD = 23'd1 << 17;
  localparam logic [22:0] MRD = 23'd1 << 15;
  localparam logic [22:0] MWR = 23'd2 << 15;
  localparam logic [22:0] NRN = 23'd4 << 12;
  localparam logic [22:0] NRD = 23'd2 << 12;
  localparam logic [22:0] NRM = 23'd1 << 12;
  localparam logic [22:0] VMD = 23'd8 << 8;
  localparam logic [22:0] VIM = 23'd4 << 8;
  localparam logic [22:0] VPC = 23'd2 << 8;
  localparam logic [22:0] VCC = 23'd1 << 8;
  localparam logic [22:0] WR  = 23'd1 << 7;
  localparam logic [22:0] LDA = 23'd1 << 6;
  localparam logic [22:0] LDB = 23'd1 << 5;
  localparam logic [22:0] LDC = 23'd1 << 4;
  localparam logic [22:0] LDS = 23'd1 << 3;
  localparam logic [22:0] ASL = 23'd1 << 2;
  localparam logic [22:0] BSL = 23'd1 << 1;
  localparam logic [22:0] HLT = 23'd1;

  p6_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond),
    .N(N), .V(V), .Z(Z),
    .load_ir(load_ir), .load_pc(load_pc), .pc_sel(pc_sel), .addr_sel(addr_sel),
    .load_addr(load_addr), .mem_cmd(mem_cmd), .nsel(nsel), .vsel(vsel),
    .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [22:0] obs();
    return {load_ir, load_pc, pc_sel, addr_sel, load_addr, mem_cmd, nsel, vsel,
            write, loada, loadb, loadc, loads, asel, bsel, halted};
  endfunction

  function automatic bit ref_taken(input logic [2:0] c, input logic n, input logic v, input logic z);
    case (c)
      3'd0:    return 1'b1;
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return n != v;
      3'd4:    return (n != v) || z;
      default: return 1'b0;
    endcase
  endfunction

  // Reference: the whole instruction's cycle-by-cycle control words
  task automatic model_instr(input logic [2:0] opc, input logic [1:0] o, input int halt_cycles);
    exp_q.delete();
    exp_q.push_back(ASE | MRD);
    exp_q.push_back(ASE | MRD | LIR);
    exp_q.push_back(LPC);
    exp_q.push_back('0);
    case ({opc, o})
      5'b110_10: exp_q.push_back(NRN | VIM | WR);
      5'b110_00: begin exp_q.push_back(NRM | LDB); exp_q.push_back(ASL | LDC); exp_q.push_back(NRD | VCC | WR); end
      5'b101_00, 5'b101_10: begin
        exp_q.push_back(NRN | LDA); exp_q.push_back(NRM | LDB);
        exp_q.push_back(LDC); exp_q.push_back(NRD | VCC | WR);
      end
      5'b101_01: begin exp_q.push_back(NRN | LDA); exp_q.push_back(NRM | LDB); exp_q.push_back(LDS); end
      5'b101_11: begin exp_q.push_back(NRM | LDB); exp_q.push_back(LDC); exp_q.push_back(NRD | VCC | WR); end
      5'b011_00: begin
        exp_q.push_back(NRN | LDA); exp_q.push_back(BSL | LDC); exp_q.push_back(LAD);
        exp_q.push_back(MRD); exp_q.push_back(NRD | VMD | WR | MRD);
      end
      5'b100_00: begin
        exp_q.push_back(NRN | LDA); exp_q.push_back(BSL | LDC); exp_q.push_back(LAD);
        exp_q.push_back(NRD | LDB); exp_q.push_back(ASL | LDC); exp_q.push_back(MWR);
      end
      5'b001_00: exp_q.push_back(ref_taken(cond, N, V, Z) ? (LPC | PC1) : 23'd0);
`ifdef P6_BRANCH_LINK_EN
      5'b010_11: begin exp_q.push_back(NRN | VPC | WR); exp_q.push_back(LPC | PC1); end
      5'b010_00: begin exp_q.push_back(NRD | LDB); exp_q.push_back(LPC | PC2); end
      5'b010_10: begin exp_q.push_back(NRN | VPC | WR); exp_q.push_back(NRD | LDB); exp_q.push_back(LPC | PC2); end
`endif
      default: for (int k = 0; k < halt_cycles; k++) exp_q.push_back(HLT);
    endcase
  endtask

  task automatic set_ir(input logic [2:0] opc, input logic [1:0] o, input logic [2:0] c);
    opcode = opc; op = o; cond = c;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs() !== (LPC | PC3)) begin
      n_bad++; $display("FAIL reset_state: got %h want %h", obs(), LPC | PC3);
    end
    reset = 1'b0;
    @(negedge clk);
    // ADD, then reset while in EXEC
    set_ir(3'b101, 2'b00, 3'd0);
    model_instr(3'b101, 2'b00, 0);
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (obs() !== exp_q[i]) begin
        n_bad++; $display("FAIL reset_add cyc%0d: got %h want %h", i, obs(), exp_q[i]);
      end
      if (i < 6) @(negedge clk);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== (LPC | PC3)) begin
      n_bad++; $display("FAIL reset_async: got %h want %h", obs(), LPC | PC3);
    end
    @(negedge clk);
    n_cmp++;
    if (obs() !== (LPC | PC3) || write !== 1'b0) begin
      n_bad++; $display("FAIL reset_hold: got %h want %h", obs(), LPC | PC3);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs() !== (ASE | MRD)) begin
      n_bad++; $display("FAIL reset_to_if1: got %h want %h", obs(), ASE | MRD);
    end
  endtask

  task automatic test_mov_imm();
    int writes = 0;
    set_ir(3'b110, 2'b10, 3'($urandom));
    model_instr(3'b110, 2'b10, 0);
    foreach (exp_q[i]) begin
      n_cmp++;
      if (obs() !== exp_q[i]) begin
        n_bad++; $display("FAIL mov_imm cyc%0d: got %h want %h", i, obs(), exp_q[i]);
      end
      if (write) writes++;
      @(negedge clk);
    end
    n_cmp++;
    if (writes != 1 || exp_q.size() != 5) begin
      n_bad++; $display("FAIL mov_imm_writes: got %0d want 1", writes);
    end
  endtask

  task automatic test_branch();
    logic [2:0] oc [6] = '{3'b101, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
    logic [1:0] oo [6] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [2:0] cc [6] = '{3'd0, 3'd3, 3'd3, 3'd4, 3'd5, 3'd0};
    logic [2:0] fl [6] = '{3'b100, 3'b100, 3'b000, 3'b001, 3'b000, 3'b000};
    for (int t = 0; t < 6; t++) begin
      set_ir(oc[t], oo[t], cc[t]);
      {N, V, Z} = fl[t];
      if (t == 4) {N, V, Z} = 3'($urandom);
      model_instr(oc[t], oo[t], 0);
      foreach (exp_q[i]) begin
        n_cmp++;
        if (obs() !== exp_q[i]) begin
          n_bad++; $display("FAIL branch%0d cyc%0d: got %h want %h", t, i, obs(), exp_q[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_ldr_str();
    int wcycles = 0;
    for (int t = 0; t < 2; t++) begin
      set_ir(t == 0 ? 3'b011 : 3'b100, 2'b00, 3'($urandom));
      model_instr(opcode, op, 0);
      foreach (exp_q[i]) begin
        n_cmp++;
        if (obs() !== exp_q[i]) begin
          n_bad++; $display("FAIL ldr_str%0d cyc%0d: got %h want %h", t, i, obs(), exp_q[i]);
        end
        if (mem_cmd == 2'd2) wcycles++;
        @(negedge clk);
      end
    end
    n_cmp++;
    if (wcycles != 1) begin
      n_bad++; $display("FAIL str_write_cycles: got %0d want 1", wcycles);
    end
  endtask

  task automatic test_random();
    logic [4:0] legal [$] = '{5'b110_10, 5'b110_00, 5'b101_00, 5'b101_01, 5'b101_10,
                              5'b101_11, 5'b011_00, 5'b100_00, 5'b001_00};
`ifdef P6_BRANCH_LINK_EN
    legal.push_back(5'b010_11); legal.push_back(5'b010_00); legal.push_back(5'b010_10);
`endif
    for (int t = 0; t < 60; t++) begin
      logic [4:0] pick;
      pick = legal[$urandom_range(0, legal.size() - 1)];
      set_ir(pick[4:2], pick[1:0], 3'($urandom));
      {N, V, Z} = 3'($urandom);
      model_instr(opcode, op, 0);
      foreach (exp_q[i]) begin
        n_cmp++;
        if (obs() !== exp_q[i]) begin
          n_bad++; $display("FAIL random%0d op%b cyc%0d: got %h want %h", t, pick, i, obs(), exp_q[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_halt();
    logic [4:0] cases [3] = '{5'b111_00, 5'b010_11, 5'b110_01};
    for (int t = 0; t < 3; t++) begin
      set_ir(cases[t][4:2], cases[t][1:0], 3'd0);
      {N, V, Z} = 3'($urandom);
      model_instr(opcode, op, 24);
      foreach (exp_q[i]) begin
        n_cmp++;
        if (obs() !== exp_q[i]) begin
          n_bad++; $display("FAIL halt%0d cyc%0d: got %h want %h", t, i, obs(), exp_q[i]);
        end
        @(negedge clk);
      end
      reset_pulse();
    end
  endtask

  initial begin
    reset = 1'b1;
    opcode = '0; op = '0; cond = '0;
    N = 1'b0; V = 1'b0; Z = 1'b0;
    test_reset();
    test_mov_imm();
    test_branch();
    test_ldr_str();
    test_random();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
